alpharetz_spi_peripheral: RTL and testbench

- SPI target (peripheral-side) endpoint for the Alpharetz SPI bus.
- Oversamples the controller's p_clk, p_sel_n and copi in the sys_clk domain, shifts a word in on copi and a reply word out on cipo.
- Hands received words to local logic through a valid pulse and accepts reply words through a ready/valid buffer.
- Used for on-chip loopback verification of the SPI controller and as the bus interface of Alpharetz-side peripherals.

---
 rtl/alpharetz_spi_peripheral.sv | 166 ++++++++++++++++
 tb/tb_alpharetz_spi_peripheral.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alpharetz_spi_peripheral.sv
// SPI target endpoint: oversamples p_clk/p_sel_n/copi in sys_clk, LSB-first words, CPHA=0.
// Received words leave as an rx_valid pulse; reply words enter through a one-deep ready/valid buffer.
module alpharetz_spi_peripheral #(
    parameter int unsigned                SPI_DATA_WIDTH = 8,
    parameter bit                         CPOL           = 1'b0,
    parameter logic [SPI_DATA_WIDTH-1:0]  TX_IDLE_WORD   = '1
) (
    input  logic                      sys_clk,
    input  logic                      async_rst_n,
    input  logic                      p_clk,
    input  logic                      p_sel_n,
    input  logic                      copi,
    output logic                      cipo,
    output logic                      cipo_oe,
    input  logic [SPI_DATA_WIDTH-1:0] tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic [SPI_DATA_WIDTH-1:0] rx_data,
    output logic                      rx_valid,
    output logic                      tx_underrun,
    output logic                      frame_err,
    output logic                      busy
);

    localparam int unsigned CntW = (SPI_DATA_WIDTH > 1) ? $clog2(SPI_DATA_WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(SPI_DATA_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

    state_e                    state;
    logic                      pclk_s1, pclk_s2, pclk_h;
    logic                      sel_s1, sel_s2, sel_h;
    logic                      copi_s1, copi_s2;
    logic [CntW-1:0]           bit_cnt;
    logic [SPI_DATA_WIDTH-1:0] rx_shift;
    logic [SPI_DATA_WIDTH-1:0] tx_shift;
    logic [SPI_DATA_WIDTH-1:0] tx_buf;
    logic                      word_done;

    logic pclk_rise, pclk_fall, lead_edge, trail_edge;
    logic sel_assert, deselect, buf_load, buf_consume;

    always_ff @(posedge sys_clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            pclk_s1 <= CPOL;
            pclk_s2 <= CPOL;
            pclk_h  <= CPOL;
            sel_s1  <= 1'b1;
            sel_s2  <= 1'b1;
            sel_h   <= 1'b1;
            copi_s1 <= 1'b0;
            copi_s2 <= 1'b0;
        end else begin
            pclk_s1 <= p_clk;
            pclk_s2 <= pclk_s1;
            pclk_h  <= pclk_s2;
            sel_s1  <= p_sel_n;
            sel_s2  <= sel_s1;
            sel_h   <= sel_s2;
            copi_s1 <= copi;
            copi_s2 <= copi_s1;
        end
    end

    always_comb begin
        pclk_rise   = pclk_s2 & ~pclk_h;
        pclk_fall   = ~pclk_s2 & pclk_h;
        lead_edge   = CPOL ? pclk_fall : pclk_rise;
        trail_edge  = CPOL ? pclk_rise : pclk_fall;
        sel_assert  = sel_h & ~sel_s2;
        deselect    = sel_s2;
        buf_load    = tx_valid & tx_ready;
        // The buffer is full exactly when tx_ready is low; a word start drains it.
        buf_consume = (state == StLoad) & ~deselect & ~tx_ready;
    end

    assign busy = (state != StIdle);

    always_ff @(posedge sys_clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state       <= StIdle;
            cipo        <= 1'b0;
            cipo_oe     <= 1'b0;
            tx_ready    <= 1'b1;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            tx_buf      <= '0;
            word_done   <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
            word_done   <= 1'b0;

            if (word_done) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
            end

            if (buf_load) begin
                tx_buf   <= tx_data;
                tx_ready <= 1'b0;
            end else if (buf_consume) begin
                tx_ready <= 1'b1;
            end

            // Deselect takes priority over any p_clk edge seen in the same cycle.
            if (state != StIdle && deselect) begin
                state   <= StIdle;
                cipo    <= 1'b0;
                cipo_oe <= 1'b0;
                bit_cnt <= '0;
                if (bit_cnt != '0) begin
                    frame_err <= 1'b1;
                end
            end else begin
                case (state)
                    StIdle: begin
                        if (sel_assert) begin
                            state <= StLoad;
                        end
                    end
                    StLoad: begin
                        if (!tx_ready) begin
                            tx_shift <= tx_buf;
                            cipo     <= tx_buf[0];
                        end else begin
                            tx_shift    <= TX_IDLE_WORD;
                            cipo        <= TX_IDLE_WORD[0];
                            tx_underrun <= 1'b1;
                        end
                        cipo_oe <= 1'b1;
                        bit_cnt <= '0;
                        state   <= StShift;
                    end
                    StShift: begin
                        if (lead_edge) begin
                            rx_shift <= {copi_s2, rx_shift[SPI_DATA_WIDTH-1:1]};
                            if (bit_cnt == LastCnt) begin
                                bit_cnt   <= '0;
                                word_done <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + CntW'(1);
                            end
                        end else if (trail_edge) begin
                            if (bit_cnt != '0) begin
                                tx_shift <= tx_shift >> 1;
                                cipo     <= tx_shift[1];
                            end else begin
                                // Word boundary: fetch the next reply for back-to-back words.
                                state <= StLoad;
                            end
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alpharetz_spi_peripheral.sv
// Bench for alpharetz_spi_peripheral: table of single words plus hand-written
// back-to-back, frame-error and mid-word reset sequences; rx words go through a scoreboard queue.
module tb_alpharetz_spi_peripheral;

    localparam int HALF = 8;

    logic       sys_clk = 1'b0;
    logic       async_rst_n = 1'b0;
    logic       p_clk = 1'b0;
    logic       p_sel_n = 1'b1;
    logic       copi = 1'b0;
    logic       cipo, cipo_oe, tx_ready, rx_valid, tx_underrun, frame_err, busy;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic [7:0] rx_data;

    int errors = 0;
    int checks = 0;
    int rx_cnt = 0;
    int und_cnt = 0;
    int fe_cnt = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] mosi;
        logic [7:0] txw;
        bit         use_tx;
        logic [7:0] exp_miso;
        int         exp_und;
    } vec_t;

    vec_t vecs[4];

    alpharetz_spi_peripheral dut (
        .sys_clk     (sys_clk),
        .async_rst_n (async_rst_n),
        .p_clk       (p_clk),
        .p_sel_n     (p_sel_n),
        .copi        (copi),
        .cipo        (cipo),
        .cipo_oe     (cipo_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge sys_clk) begin
        #1;
        if (tx_underrun === 1'b1) und_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
        if (rx_valid === 1'b1) begin
            rx_cnt++;
            if (exp_q.size() == 0) begin
                chk("rx_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
            end else begin
                chk("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic send_tx(input logic [7:0] d);
        bit ok = 1'b0;
        @(negedge sys_clk);
        tx_data  = d;
        tx_valid = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
        if (!ok) chk("tx_handshake_timeout", 32'd0, 32'd1);
        @(negedge sys_clk);
        tx_valid = 1'b0;
    endtask

    // Controller side: CPOL=0, CPHA=0, LSB first; miso sampled at each leading edge.
    task automatic xfer(input logic [7:0] mosi, input int nbits, input bit first, input bit last,
                        output logic [7:0] miso);
        miso = 8'h00;
        if (first) begin
            @(negedge sys_clk);
            p_sel_n = 1'b0;
        end
        for (int i = 0; i < nbits; i++) begin
            @(negedge sys_clk);
            copi = mosi[i];
            repeat (HALF) @(negedge sys_clk);
            p_clk   = 1'b1;
            miso[i] = cipo;
            if (i == 0 && first) chk("cipo_oe_active", 32'(cipo_oe), 32'd1);
            repeat (HALF) @(negedge sys_clk);
            if (i == nbits - 1 && last) begin
                p_sel_n = 1'b1;
                repeat (2) @(negedge sys_clk);
            end
            p_clk = 1'b0;
        end
        if (last) repeat (HALF) @(negedge sys_clk);
    endtask

    task automatic run_word(input logic [7:0] mosi, input logic [7:0] txw, input bit use_tx,
                            input logic [7:0] exp_miso, input int exp_und);
        logic [7:0] miso;
        int u0 = und_cnt;
        int r0 = rx_cnt;
        int f0 = fe_cnt;
        if (use_tx) begin
            send_tx(txw);
            chk("tx_ready_full", 32'(tx_ready), 32'd0);
        end
        exp_q.push_back(mosi);
        xfer(mosi, 8, 1'b1, 1'b1, miso);
        repeat (10) @(negedge sys_clk);
        chk("miso", 32'(miso), 32'(exp_miso));
        chk("underrun_pulses", 32'(und_cnt - u0), 32'(exp_und));
        chk("rx_pulses", 32'(rx_cnt - r0), 32'd1);
        chk("frame_err_none", 32'(fe_cnt - f0), 32'd0);
        chk("tx_ready_after", 32'(tx_ready), 32'd1);
        chk("busy_after", 32'(busy), 32'd0);
        chk("cipo_oe_after", 32'(cipo_oe), 32'd0);
    endtask

    initial begin
        logic [7:0] m1, m2;
        int u0, r0, f0;

        vecs[0] = '{mosi: 8'h3C, txw: 8'hA5, use_tx: 1'b1, exp_miso: 8'hA5, exp_und: 0};
        vecs[1] = '{mosi: 8'h00, txw: 8'h00, use_tx: 1'b0, exp_miso: 8'hFF, exp_und: 1};
        vecs[2] = '{mosi: 8'hFF, txw: 8'h00, use_tx: 1'b1, exp_miso: 8'h00, exp_und: 0};
        vecs[3] = '{mosi: 8'h81, txw: 8'h7E, use_tx: 1'b1, exp_miso: 8'h7E, exp_und: 0};

        // Reset held, then released with idle pins.
        repeat (4) @(negedge sys_clk);
        chk("rst_cipo_oe", 32'(cipo_oe), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        async_rst_n = 1'b1;
        repeat (20) @(negedge sys_clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_cipo_oe", 32'(cipo_oe), 32'd0);
        chk("idle_rx_pulses", 32'(rx_cnt), 32'd0);

        foreach (vecs[k]) begin
            run_word(vecs[k].mosi, vecs[k].txw, vecs[k].use_tx, vecs[k].exp_miso, vecs[k].exp_und);
        end

        // Back-to-back words, second reply supplied while the first word is in flight.
        u0 = und_cnt;
        r0 = rx_cnt;
        send_tx(8'h11);
        exp_q.push_back(8'hC7);
        exp_q.push_back(8'h2E);
        fork
            begin
                xfer(8'hC7, 8, 1'b1, 1'b0, m1);
                xfer(8'h2E, 8, 1'b0, 1'b1, m2);
            end
            send_tx(8'h22);
        join
        repeat (10) @(negedge sys_clk);
        chk("b2b_miso0", 32'(m1), 32'h11);
        chk("b2b_miso1", 32'(m2), 32'h22);
        chk("b2b_rx_pulses", 32'(rx_cnt - r0), 32'd2);
        chk("b2b_underrun", 32'(und_cnt - u0), 32'd0);

        // Deselect after 5 bits.
        r0 = rx_cnt;
        f0 = fe_cnt;
        xfer(8'h13, 5, 1'b1, 1'b1, m1);
        repeat (10) @(negedge sys_clk);
        chk("ferr_pulses", 32'(fe_cnt - f0), 32'd1);
        chk("ferr_no_rx", 32'(rx_cnt - r0), 32'd0);
        chk("ferr_busy", 32'(busy), 32'd0);
        run_word(8'h96, 8'h00, 1'b0, 8'hFF, 1);

        // Reset in the middle of a word.
        r0 = rx_cnt;
        send_tx(8'h77);
        xfer(8'hE1, 3, 1'b1, 1'b0, m1);
        @(negedge sys_clk);
        #2 async_rst_n = 1'b0;
        #1;
        chk("mrst_cipo", 32'(cipo), 32'd0);
        chk("mrst_cipo_oe", 32'(cipo_oe), 32'd0);
        chk("mrst_tx_ready", 32'(tx_ready), 32'd1);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_rx_data", 32'(rx_data), 32'd0);
        chk("mrst_rx_valid", 32'(rx_valid), 32'd0);
        p_sel_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        async_rst_n = 1'b1;
        repeat (10) @(negedge sys_clk);
        chk("mrst_no_rx", 32'(rx_cnt - r0), 32'd0);
        run_word(8'h5A, 8'hC3, 1'b1, 8'hC3, 0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
